// File: rtl/intersection_model.sv
// intersection_model: road-side model of the traffic-light loop; queues cars, drains on green, checks light safety.
// Optional starvation watch enabled by defining STARVATION_WATCH_EN.
module intersection_model #(
    parameter int QW = 4,
    parameter int DEPART_CYCLES = 2,
    parameter int STARVE_LIMIT = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          arrive_a,
    input  logic          arrive_b,
    input  logic [2:0]    LA,
    input  logic [2:0]    LB,
    output logic          SA,
    output logic          SB,
    output logic [QW-1:0] qa,
    output logic [QW-1:0] qb,
    output logic          depart_a,
    output logic          depart_b,
    output logic [1:0]    overflow,
    output logic          violation,
    output logic [1:0]    viol_code,
    output logic [1:0]    starve
);
    localparam int TW = $clog2(DEPART_CYCLES) + 1;
    localparam logic [QW-1:0] QMAX = '1;
    typedef enum logic [1:0] {RED, YEL, GRN, ILL} phase_t;
    phase_t light [2];
    phase_t state [2];
    phase_t state_next [2];
    logic [QW-1:0] q [2];
    logic [QW-1:0] q_next [2];
    logic [TW-1:0] tmr [2];
    logic [TW-1:0] tmr_next [2];
    logic [1:0] arr, dep, dp, ovf_set, bad_tr;
    logic ill, conflict;
    logic [1:0] code;
    function automatic phase_t decode(input logic [2:0] c);
        return c == 3'b001 ? RED : c == 3'b011 ? YEL : c == 3'b111 ? GRN : ILL;
    endfunction
    always_comb begin
        light[0] = decode(LA);
        light[1] = decode(LB);
        arr = {arrive_b, arrive_a};
        for (int i = 0; i < 2; i++) begin
            dep[i] = light[i] == GRN && q[i] != '0 && tmr[i] == TW'(DEPART_CYCLES - 1);
            tmr_next[i] = (light[i] != GRN || q[i] == '0 || dep[i]) ? '0 : tmr[i] + 1'b1;
            ovf_set[i] = arr[i] && !dep[i] && q[i] == QMAX;
            q_next[i] = arr[i] == dep[i] ? q[i] : arr[i] ? (ovf_set[i] ? q[i] : q[i] + 1'b1) : q[i] - 1'b1;
            state_next[i] = light[i] == ILL ? state[i] : light[i];
            bad_tr[i] = (state[i] == RED && light[i] == GRN) || (state[i] == GRN && light[i] == RED);
        end
        ill = light[0] == ILL || light[1] == ILL;
        conflict = (light[0] == YEL || light[0] == GRN) && (light[1] == YEL || light[1] == GRN);
        code = ill ? 2'b01 : conflict ? 2'b10 : |bad_tr ? 2'b11 : 2'b00;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                q[i] <= '0;
                tmr[i] <= '0;
                state[i] <= RED;
            end
            dp <= '0;
            overflow <= '0;
            violation <= 1'b0;
            viol_code <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                q[i] <= q_next[i];
                tmr[i] <= tmr_next[i];
                state[i] <= state_next[i];
            end
            dp <= dep;
            overflow <= overflow | ovf_set;
            violation <= violation | (code != 2'b00);
            viol_code <= violation ? viol_code : code;
        end
    end
    assign qa = q[0];
    assign qb = q[1];
    assign SA = q[0] != '0;
    assign SB = q[1] != '0;
    assign depart_a = dp[0];
    assign depart_b = dp[1];
`ifdef STARVATION_WATCH_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);
    logic [WW-1:0] wt [2];
    logic [WW-1:0] wt_next [2];
    always_comb begin
        for (int i = 0; i < 2; i++)
            wt_next[i] = (q[i] == '0 || light[i] != RED) ? '0 : wt[i] == WW'(STARVE_LIMIT) ? wt[i] : wt[i] + 1'b1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) wt[i] <= '0;
            starve <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                wt[i] <= wt_next[i];
                starve[i] <= starve[i] | (wt_next[i] == WW'(STARVE_LIMIT));
            end
        end
    end
`else
    // STARVE_LIMIT only matters when the watch is built
    assign starve = 2'b00 & 2'(STARVE_LIMIT);
`endif
endmodule

// File: tb/tb_intersection_model.sv
// tb_intersection_model: directed and random stimulus checked against a per-cycle behavioural road model.
module tb_intersection_model;
    localparam int QW = 4;
    localparam int D = 2;
    localparam int LIMIT = 32;
    localparam int QMAX = (1 << QW) - 1;
    logic clk = 0;
    logic reset;
    logic arrive_a, arrive_b;
    logic [2:0] LA, LB;
    logic SA, SB, depart_a, depart_b, violation;
    logic [QW-1:0] qa, qb;
    logic [1:0] overflow, viol_code, starve;
    int checks = 0;
    int errors = 0;
    int mq [2], streak [2], ph [2], wt [2], mcode;
    bit md [2], mo [2], ms [2], mv;
    int sch;

    intersection_model #(.QW(QW), .DEPART_CYCLES(D), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .arrive_a(arrive_a), .arrive_b(arrive_b), .LA(LA), .LB(LB),
        .SA(SA), .SB(SB), .qa(qa), .qb(qb), .depart_a(depart_a), .depart_b(depart_b),
        .overflow(overflow), .violation(violation), .viol_code(viol_code), .starve(starve)
    );

    always #5 clk = ~clk;

    function automatic int lvl(input logic [2:0] c);
        return c == 3'b001 ? 0 : c == 3'b011 ? 1 : c == 3'b111 ? 2 : -1;
    endfunction

    function automatic logic [2:0] code_of(input int p);
        return p == 0 ? 3'b001 : p == 1 ? 3'b011 : 3'b111;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; streak[i] = 0; ph[i] = 0; wt[i] = 0;
            md[i] = 0; mo[i] = 0; ms[i] = 0;
        end
        mv = 0;
        mcode = 0;
    endtask

    task automatic model(input logic a, input logic b, input logic [2:0] la, input logic [2:0] lb);
        int lv [2];
        bit arr [2];
        bit ill, con, tr, go, d;
        int code;
        arr[0] = a; arr[1] = b;
        lv[0] = lvl(la); lv[1] = lvl(lb);
        ill = lv[0] < 0 || lv[1] < 0;
        con = lv[0] > 0 && lv[1] > 0;
        tr = 0;
        for (int i = 0; i < 2; i++) begin
            if (lv[i] >= 0 && (lv[i] - ph[i] == 2 || ph[i] - lv[i] == 2)) tr = 1;
            wt[i] = (mq[i] > 0 && lv[i] == 0) ? (wt[i] < LIMIT ? wt[i] + 1 : LIMIT) : 0;
            if (wt[i] == LIMIT) ms[i] = 1;
            go = lv[i] == 2 && mq[i] > 0;
            streak[i] = go ? streak[i] + 1 : 0;
            d = go && (streak[i] % D == 0);
            if (arr[i] && !d) begin
                if (mq[i] < QMAX) mq[i]++;
                else mo[i] = 1;
            end else if (!arr[i] && d) mq[i]--;
            md[i] = d;
            if (lv[i] >= 0) ph[i] = lv[i];
        end
        code = ill ? 1 : con ? 2 : tr ? 3 : 0;
        if (!mv && code != 0) begin
            mv = 1;
            mcode = code;
        end
    endtask

    task automatic check_all();
        chk("qa", 8'(qa), 8'(mq[0]));
        chk("qb", 8'(qb), 8'(mq[1]));
        chk("SA", 8'(SA), 8'(mq[0] != 0));
        chk("SB", 8'(SB), 8'(mq[1] != 0));
        chk("depart_a", 8'(depart_a), 8'(md[0]));
        chk("depart_b", 8'(depart_b), 8'(md[1]));
        chk("overflow", 8'(overflow), 8'({mo[1], mo[0]}));
        chk("violation", 8'(violation), 8'(mv));
        chk("viol_code", 8'(viol_code), 8'(mcode));
`ifdef STARVATION_WATCH_EN
        chk("starve", 8'(starve), 8'({ms[1], ms[0]}));
`else
        chk("starve", 8'(starve), 8'h00);
`endif
    endtask

    task automatic step(input logic a, input logic b, input logic [2:0] la, input logic [2:0] lb);
        arrive_a = a; arrive_b = b; LA = la; LB = lb;
        @(posedge clk);
        model(a, b, la, lb);
        #1 check_all();
    endtask

    task automatic do_reset();
        arrive_a = 1; arrive_b = 1;
        #2 reset = 0;
        #1 model_reset();
        check_all();
        @(posedge clk);
        #1 check_all();
        reset = 1; arrive_a = 0; arrive_b = 0; LA = 3'b001; LB = 3'b001;
    endtask

    initial begin
        reset = 1; arrive_a = 0; arrive_b = 0; LA = 3'b001; LB = 3'b001;
        model_reset();
        #1 reset = 0;
        #1 check_all();
        @(posedge clk);
        #1 check_all();
        reset = 1;
        // street A to green legally, three arrivals, drain
        step(0, 0, 3'b011, 3'b001);
        for (int i = 0; i < 3; i++) step(1, 0, 3'b111, 3'b001);
        for (int i = 0; i < 8; i++) step(0, 0, 3'b111, 3'b001);
        // build qa=2 on yellow, then arrive on the departure cycle
        step(1, 0, 3'b011, 3'b001);
        step(1, 0, 3'b011, 3'b001);
        step(0, 0, 3'b111, 3'b001);
        step(1, 0, 3'b111, 3'b001);
        step(0, 0, 3'b011, 3'b001);
        step(0, 0, 3'b001, 3'b001);
        // B saturation on red
        for (int i = 0; i < 20; i++) step(0, 1, 3'b001, 3'b001);
        do_reset();
        // direct red to green
        step(0, 0, 3'b001, 3'b001);
        step(0, 0, 3'b111, 3'b001);
        do_reset();
        // conflict then an illegal code that must not overwrite the cause
        step(0, 0, 3'b011, 3'b001);
        step(0, 0, 3'b111, 3'b001);
        step(0, 0, 3'b111, 3'b011);
        step(0, 0, 3'b101, 3'b001);
        do_reset();
        step(0, 0, 3'b101, 3'b001);
        do_reset();
        // B waits on red with one car
        step(0, 1, 3'b001, 3'b001);
        for (int i = 0; i < 34; i++) step(0, 0, 3'b001, 3'b001);
        do_reset();
        // random arrivals with a legal light schedule
        sch = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(5) == 0) sch = (sch + 1) % 6;
            step($urandom_range(2) == 0, $urandom_range(2) == 0,
                 code_of(sch == 1 ? 2 : (sch == 0 || sch == 2) ? 1 : 0),
                 code_of(sch == 4 ? 2 : (sch == 3 || sch == 5) ? 1 : 0));
        end
        do_reset();
        // random codes including illegal ones
        for (int n = 0; n < 100; n++)
            step($urandom_range(1) == 1, $urandom_range(1) == 1,
                 $urandom_range(3) == 0 ? 3'($urandom_range(7)) : code_of($urandom_range(2)),
                 $urandom_range(3) == 0 ? 3'($urandom_range(7)) : code_of($urandom_range(2)));
        do_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
